// File: rtl/mult_sequencer.sv
// Round-robin arbiter and bit-serial sequencer for the shared Q5.10 sign-magnitude multiplier.
// One operand pair is granted at a time, its weight is streamed MSB-first over 16 enabled cycles, then the product is returned.
module mult_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int DATA_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_neuron,
  input  logic [NUM_REQ*DATA_W-1:0]   req_weight,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           mult_neuron,
  output logic                        mult_wbit,
  output logic                        mult_en,
  input  logic [DATA_W-1:0]           mult_out,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  input  logic                        rsp_ready,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, RUN, CAPT, RESP} state_t;

  state_t              state, state_nx;
  logic [ID_W-1:0]     rr_ptr, id_reg, gnt_idx, ptr_nx;
  logic [3:0]          bit_cnt;
  logic [DATA_W-1:0]   wreg, sel_neuron, sel_weight;
  logic [NUM_REQ-1:0]  gnt_vec;
  logic                gnt_any;

  // Search upward from rr_ptr, wrapping at NUM_REQ; first valid requester wins.
  always_comb begin
    int s;
    s          = 0;
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    gnt_vec    = '0;
    sel_neuron = '0;
    sel_weight = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[s]) begin
        gnt_any    = 1'b1;
        gnt_idx    = ID_W'(s);
        gnt_vec[s] = 1'b1;
        sel_neuron = req_neuron[s*DATA_W +: DATA_W];
        sel_weight = req_weight[s*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_nx = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign busy   = (state != IDLE);

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    mult_en   = 1'b0;
    mult_wbit = 1'b0;
    case (state)
      IDLE: begin
        // Gate on reset so no strobe leaks out while the block is held in reset.
        if (reset && gnt_any) begin
          req_ready = gnt_vec;
          state_nx  = RUN;
        end
      end
      RUN: begin
        mult_en   = 1'b1;
        mult_wbit = (bit_cnt == 4'd15) ? wreg[15] : wreg[4'd14 - bit_cnt];
        if (bit_cnt == 4'd15) state_nx = CAPT;
      end
      CAPT: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      bit_cnt     <= '0;
      wreg        <= '0;
      id_reg      <= '0;
      mult_neuron <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            mult_neuron <= sel_neuron;
            wreg        <= sel_weight;
            id_reg      <= gnt_idx;
            rr_ptr      <= ptr_nx;
            bit_cnt     <= '0;
          end
        end
        RUN:  bit_cnt <= bit_cnt + 4'd1;
        CAPT: begin
          rsp_data  <= mult_out;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Controller and arbiter for the shared bit-serial Q5.10 sign-magnitude multiplier in the accelerator datapath.
- Accepts neuron/weight pairs from NUM_REQ requesters and grants one requester at a time, round-robin.
- Streams the weight into the multiplier one bit per cycle over exactly 16 enabled cycles, then captures the multiplier output.
- Returns the result, tagged with the requester id, over a valid/ready response port.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ID_W, 3, width of the requester id field; must satisfy 2^ID_W >= NUM_REQ.
- DATA_W, 16, operand/result width; fixed at 16, Q5.10 sign-magnitude (bit 15 sign, 14:10 integer, 9:0 fraction).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_neuron  in  16*NUM_REQ  per-requester neuron; requester i at bits [16i+15:16i].
- req_weight  in  16*NUM_REQ  per-requester weight, same packing.
- req_ready  out  NUM_REQ  one-hot accept strobe; combinational.
- mult_neuron  out  16  neuron operand to the multiplier; held stable while busy.
- mult_wbit  out  1  serial weight bit to the multiplier.
- mult_en  out  1  multiplier enable.
- mult_out  in  16  multiplier result.
- rsp_valid  out  1  result valid.
- rsp_data  out  16  result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, reset=0): state IDLE, rr_ptr=0, bit_cnt=0, mult_en=0, mult_wbit=0, mult_neuron=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0. req_ready is 0 while reset is asserted.
- Reset mid-operation aborts the transfer immediately. No response is issued and the partial product is discarded.
- The multiplier's internal counter is not cleared by this block. The sequencer therefore always issues exactly 16 consecutive mult_en cycles per operation and never truncates a run except through reset.
- States:
  - IDLE:
    - If any req_valid is set, grant the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
    - req_ready[g]=1 in that cycle only. On the edge, latch neuron into mult_neuron, latch weight into wreg, latch g into id_reg.
    - Set rr_ptr=(g+1) mod NUM_REQ, set bit_cnt=0, go to RUN.
    - No req_valid: stay in IDLE, all req_ready=0.
  - RUN, 16 cycles, bit_cnt 0..15:
    - mult_en=1 throughout.
    - mult_wbit=wreg[14-bit_cnt] for bit_cnt 0..14 (magnitude, MSB first); mult_wbit=wreg[15] (sign) at bit_cnt=15.
    - bit_cnt increments each cycle. When bit_cnt=15, go to CAPT.
  - CAPT, 1 cycle:
    - mult_en=0. The multiplier result is valid at this point.
    - On the edge, rsp_data<=mult_out, rsp_id<=id_reg, rsp_valid<=1. Go to RESP.
  - RESP:
    - Hold rsp_valid, rsp_data and rsp_id stable until rsp_ready=1.
    - On the handshake edge, clear rsp_valid and go to IDLE.
- Latency: accept edge T; mult_en high during cycles T+1..T+16; rsp_valid high from T+18.
- Throughput: with rsp_ready tied high, one result per 19 cycles.
- No new grant while busy. req_ready stays 0 in RUN, CAPT and RESP even if req_valid is high.
- Requester operands need not stay stable after their accept cycle; all operands are latched.
- req_valid withdrawn before grant: no effect. Simultaneous requests: rr_ptr ordering decides.
- rsp_ready high while rsp_valid is low is ignored.
- Requester indices >= NUM_REQ never appear on rsp_id.

Test Plan:
- Single op, requester 0, neuron 0x0400, weight 0x8003:
  - req_ready[0] pulses once.
  - mult_en high for exactly 16 cycles.
  - mult_wbit sequence is 0×13, 1, 1, then 1 (sign).
  - mult_neuron=0x0400 throughout the run.
  - rsp_valid rises 18 cycles after the accept edge with rsp_id=0 and rsp_data equal to the multiplier model's output.
- Both requesters hold valid continuously, rsp_ready=1:
  - Grants alternate 0,1,0,1.
  - rsp_id sequence is 0,1,0,1.
  - Results 19 cycles apart.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises:
  - rsp_data and rsp_id remain stable.
  - req_ready stays 0.
  - The next grant occurs only after the handshake.
- Async reset asserted at bit_cnt=7:
  - mult_en, rsp_valid and busy go 0 without waiting for a clock edge.
  - After release, the first request restarts with rr_ptr=0 and gets a full 16-bit run.
- NUM_REQ=3, only requester 2 valid:
  - Granted from rr_ptr=0.
  - rr_ptr becomes 0.
  - rsp_id=2.
- Requester 1 drops req_valid one cycle before a grant would reach it: no grant to 1 and no response with rsp_id=1.
